reward_place_ctrl: RTL and testbench
====================================

# reward_place_ctrl

Scheduler that sequences reward placement for the snake game. It paces spawns on the 4 Hz game tick and pulls candidate position/type from the random reward source over a request/valid handshake. Each candidate is checked against the board occupancy map, and rejects are retried. The block holds the placed reward until the snake head eats it or it expires, and reports score increments to the score logic.

## Interface
- BASE_TIME, 20: ticks spent in WAIT before a spawn attempt (1..255)
- STAY_TIME, 40: ticks a placed reward survives (REWARD_TIMEOUT_EN only, 1..255)
- MAX_RETRY, 7: consecutive rejected candidates before abandoning a spawn (1..7)
- X_MIN / X_MAX, 4 / 19: legal reward column range, inclusive
- Y_MIN / Y_MAX, 2 / 9: legal reward row range, inclusive
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset; asynchronous assert, active-low
- enable  in  1  game running; low aborts to WAIT
- tick  in  1  one-clk pulse at 4 Hz, synchronous to clk
- cand_req  out  1  request for a new candidate; level
- cand_valid  in  1  candidate present; accepted when cand_req & cand_valid
- cand_xpos, cand_ypos  in  6 each  candidate coordinates
- cand_type  in  2  candidate reward type, 0 = none
- occ_req  out  1  occupancy query; level, held until occ_ack
- occ_x, occ_y  out  6 each  query coordinates, stable while occ_req
- occ_ack  in  1  one-clk query answer strobe
- occ_hit  in  1  cell occupied; sampled only with occ_ack
- head_valid  in  1  one-clk strobe: snake head moved
- head_x, head_y  in  6 each  new head coordinates
- reward_valid  out  1  reward on board
- reward_xpos, reward_ypos  out  6 each  reward coordinates; 0 when not valid
- reward_type  out  2  placed type; 0 when not valid
- eaten  out  1  one-clk pulse: reward eaten
- score_add  out  3  increment value, non-zero only during eaten
- place_fail  out  1  one-clk pulse: spawn abandoned after MAX_RETRY rejects

## Operation
- States: WAIT, REQ, CHECK, SHOW. Reset puts the block in WAIT.
- Counters: tick_cnt is 8 bits and retry_cnt is 3 bits; both are 0 in reset.
- All outputs are 0 in reset.
- WAIT:
  - tick_cnt increments on each tick.
  - When tick_cnt reaches BASE_TIME on a tick, clear tick_cnt and go to REQ.
- REQ:
  - cand_req is high.
  - On acceptance, latch x/y/type and drop cand_req the next cycle.
  - If type==0 or a coordinate is out of range, the candidate is rejected without a query.
  - Otherwise go to CHECK.
- CHECK:
  - occ_req is high with the latched coordinates until occ_ack.
  - occ_hit=0: go to SHOW and clear retry_cnt.
  - occ_hit=1: treat as a reject.
- Reject handling:
  - A reject increments retry_cnt and returns to REQ.
  - If retry_cnt+1 == MAX_RETRY, pulse place_fail, clear retry_cnt and go to WAIT.
- SHOW:
  - reward_valid=1 and the latched outputs are driven.
  - head_valid with head_x==reward_xpos and head_y==reward_ypos means the reward is eaten:
    - pulse eaten with score_add = 1/2/5 for type 1/2/3;
    - clear the outputs and go to WAIT.
- Enable:
  - enable=0 in any state goes to WAIT the next cycle and clears counters, reward outputs, cand_req and occ_req.
  - tick and head_valid are ignored while enable=0.
- A tick arriving in REQ or CHECK is ignored; no pacing applies during placement.

## Timing
- Candidate acceptance to occ_req high: 1 cycle.
- occ_ack with occ_hit=0 to reward_valid high: 1 cycle, i.e. the next rising edge.
- Eat detection: eaten high the cycle after the matching head_valid. reward_valid falls on the same edge.
- Eat and expiry on the same cycle: eat wins, giving an eaten pulse with no silent expiry.
- occ_ack arriving while occ_req is low: ignored.
- cand_valid arriving while cand_req is low: ignored.
- Reset asserted mid-handshake: occ_req and cand_req drop asynchronously. Requesters must tolerate the abandoned transaction.

## Configuration
- REWARD_TIMEOUT_EN defined:
  - In SHOW, tick_cnt counts ticks.
  - On the tick where tick_cnt reaches STAY_TIME, clear the reward (no eaten pulse) and go to WAIT.
- REWARD_TIMEOUT_EN undefined:
  - The reward persists in SHOW until eaten or enable=0.
  - STAY_TIME is unused.

## Test plan
- Clean spawn: enable=1, 20 ticks, then a candidate (10,5,type 2) with occ_hit=0 → reward_valid=1 at (10,5), type 2, one cycle after occ_ack.
- Eat: reward at (10,5) type 3, head_valid at (10,5) → eaten for 1 cycle with score_add=5, reward_valid=0, back in WAIT.
- Retry limit, MAX_RETRY=7: 7 candidates that are occupied or out of range, e.g. x=30 → exactly one place_fail pulse, no reward_valid, WAIT.
- Timeout with REWARD_TIMEOUT_EN: reward placed and 40 ticks with no match → reward_valid drops, eaten stays 0. Without the macro, reward_valid is still 1 after 100 ticks.
- Same-cycle eat and expiry: matching head_valid on the 40th tick → eaten=1 with score_add set.
- Abort: enable=0 while occ_req is high → occ_req=0 next cycle, all outputs 0, state WAIT. A late occ_ack is ignored.

Source files
------------

// File: rtl/reward_place_ctrl_if.sv
// Handshake and status bundle between reward_place_ctrl and the rest of the snake game.
// The master view belongs to the controller; the slave view belongs to the game environment.
interface reward_place_ctrl_if;
  logic       cand_req;
  logic       cand_valid;
  logic [5:0] cand_xpos;
  logic [5:0] cand_ypos;
  logic [1:0] cand_type;

  logic       occ_req;
  logic [5:0] occ_x;
  logic [5:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;

  logic       head_valid;
  logic [5:0] head_x;
  logic [5:0] head_y;

  logic       reward_valid;
  logic [5:0] reward_xpos;
  logic [5:0] reward_ypos;
  logic [1:0] reward_type;
  logic       eaten;
  logic [2:0] score_add;
  logic       place_fail;

  modport master (
    output cand_req,
    input  cand_valid, cand_xpos, cand_ypos, cand_type,
    output occ_req, occ_x, occ_y,
    input  occ_ack, occ_hit,
    input  head_valid, head_x, head_y,
    output reward_valid, reward_xpos, reward_ypos, reward_type,
    output eaten, score_add, place_fail
  );

  modport slave (
    input  cand_req,
    output cand_valid, cand_xpos, cand_ypos, cand_type,
    input  occ_req, occ_x, occ_y,
    output occ_ack, occ_hit,
    output head_valid, head_x, head_y,
    input  reward_valid, reward_xpos, reward_ypos, reward_type,
    input  eaten, score_add, place_fail
  );
endinterface

// File: rtl/reward_place_ctrl.sv
// Reward placement scheduler: paces spawns on the game tick, vets candidates against the board
// and holds the reward until eaten. Define REWARD_TIMEOUT_EN to expire rewards after STAY_TIME ticks.
module reward_place_ctrl #(
  parameter int BASE_TIME = 20,
  parameter int STAY_TIME = 40,
  parameter int MAX_RETRY = 7,
  parameter int X_MIN     = 4,
  parameter int X_MAX     = 19,
  parameter int Y_MIN     = 2,
  parameter int Y_MAX     = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 tick,
  reward_place_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_WAIT, S_REQ, S_CHECK, S_SHOW} state_t;

  localparam logic [7:0] BASE_T  = 8'(BASE_TIME);
`ifdef REWARD_TIMEOUT_EN
  localparam logic [7:0] STAY_T  = 8'(STAY_TIME);
`endif
  localparam logic [2:0] RETRY_T = 3'(MAX_RETRY);
  localparam logic [5:0] XLO     = 6'(X_MIN);
  localparam logic [5:0] XHI     = 6'(X_MAX);
  localparam logic [5:0] YLO     = 6'(Y_MIN);
  localparam logic [5:0] YHI     = 6'(Y_MAX);

  // An illegal timing configuration keeps the block parked in WAIT instead of misbehaving.
  localparam bit CFG_OK = (BASE_TIME >= 1) && (BASE_TIME <= 255) &&
                          (STAY_TIME >= 1) && (STAY_TIME <= 255) &&
                          (MAX_RETRY >= 1) && (MAX_RETRY <= 7);

  state_t     state, state_nxt;
  logic [7:0] tick_cnt, tick_nxt, tick_inc;
  logic [2:0] retry_cnt, retry_nxt;
  logic [5:0] lat_x, lat_y, lat_x_nxt, lat_y_nxt;
  logic [1:0] lat_type, lat_type_nxt;
  logic       cand_taken, cand_taken_nxt;
  logic       eaten_q, eaten_nxt;
  logic       fail_q, fail_nxt;
  logic [2:0] score_q, score_nxt;

  logic run;
  logic cand_req;
  logic occ_req;
  logic show;
  logic accept;
  logic cand_ok;
  logic head_hit;
  logic reject;

  function automatic logic [2:0] score_of(input logic [1:0] t);
    logic [2:0] s;
    unique case (t)
      2'd1:    s = 3'd1;
      2'd2:    s = 3'd2;
      2'd3:    s = 3'd5;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  assign run      = enable & CFG_OK;
  assign tick_inc = tick_cnt + 8'd1;
  assign show     = (state == S_SHOW);

  // cand_req drops for one cycle after each acceptance so the source can present a fresh candidate.
  assign cand_req = run && (state == S_REQ) && !cand_taken;
  assign occ_req  = run && (state == S_CHECK);
  assign accept   = cand_req && bus.cand_valid;

  assign cand_ok  = (bus.cand_type != 2'd0) &&
                    (bus.cand_xpos >= XLO) && (bus.cand_xpos <= XHI) &&
                    (bus.cand_ypos >= YLO) && (bus.cand_ypos <= YHI);

  assign head_hit = bus.head_valid && (bus.head_x == lat_x) && (bus.head_y == lat_y);

  assign bus.cand_req     = cand_req;
  assign bus.occ_req      = occ_req;
  assign bus.occ_x        = occ_req ? lat_x : 6'd0;
  assign bus.occ_y        = occ_req ? lat_y : 6'd0;
  assign bus.reward_valid = show;
  assign bus.reward_xpos  = show ? lat_x : 6'd0;
  assign bus.reward_ypos  = show ? lat_y : 6'd0;
  assign bus.reward_type  = show ? lat_type : 2'd0;
  assign bus.eaten        = eaten_q;
  assign bus.score_add    = score_q;
  assign bus.place_fail   = fail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      tick_cnt   <= 8'd0;
      retry_cnt  <= 3'd0;
      lat_x      <= 6'd0;
      lat_y      <= 6'd0;
      lat_type   <= 2'd0;
      cand_taken <= 1'b0;
      eaten_q    <= 1'b0;
      score_q    <= 3'd0;
      fail_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_nxt;
      retry_cnt  <= retry_nxt;
      lat_x      <= lat_x_nxt;
      lat_y      <= lat_y_nxt;
      lat_type   <= lat_type_nxt;
      cand_taken <= cand_taken_nxt;
      eaten_q    <= eaten_nxt;
      score_q    <= score_nxt;
      fail_q     <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    tick_nxt       = tick_cnt;
    retry_nxt      = retry_cnt;
    lat_x_nxt      = lat_x;
    lat_y_nxt      = lat_y;
    lat_type_nxt   = lat_type;
    cand_taken_nxt = 1'b0;
    eaten_nxt      = 1'b0;
    score_nxt      = 3'd0;
    fail_nxt       = 1'b0;
    reject         = 1'b0;

    if (!run) begin
      state_nxt    = S_WAIT;
      tick_nxt     = 8'd0;
      retry_nxt    = 3'd0;
      lat_x_nxt    = 6'd0;
      lat_y_nxt    = 6'd0;
      lat_type_nxt = 2'd0;
    end else begin
      unique case (state)
        S_WAIT: begin
          if (tick) begin
            if (tick_inc == BASE_T) begin
              tick_nxt  = 8'd0;
              state_nxt = S_REQ;
            end else begin
              tick_nxt = tick_inc;
            end
          end
        end
        S_REQ: begin
          if (accept) begin
            cand_taken_nxt = 1'b1;
            lat_x_nxt      = bus.cand_xpos;
            lat_y_nxt      = bus.cand_ypos;
            lat_type_nxt   = bus.cand_type;
            if (cand_ok) state_nxt = S_CHECK;
            else         reject    = 1'b1;
          end
        end
        S_CHECK: begin
          if (bus.occ_ack) begin
            if (bus.occ_hit) begin
              reject = 1'b1;
            end else begin
              state_nxt = S_SHOW;
              retry_nxt = 3'd0;
            end
          end
        end
        S_SHOW: begin
          // An eat on the expiry tick still scores: the head match is checked first.
          if (head_hit) begin
            eaten_nxt    = 1'b1;
            score_nxt    = score_of(lat_type);
            state_nxt    = S_WAIT;
            tick_nxt     = 8'd0;
            lat_x_nxt    = 6'd0;
            lat_y_nxt    = 6'd0;
            lat_type_nxt = 2'd0;
          end
`ifdef REWARD_TIMEOUT_EN
          else if (tick) begin
            if (tick_inc == STAY_T) begin
              state_nxt    = S_WAIT;
              tick_nxt     = 8'd0;
              lat_x_nxt    = 6'd0;
              lat_y_nxt    = 6'd0;
              lat_type_nxt = 2'd0;
            end else begin
              tick_nxt = tick_inc;
            end
          end
`endif
        end
        default: state_nxt = S_WAIT;
      endcase

      if (reject) begin
        if (retry_cnt + 3'd1 == RETRY_T) begin
          fail_nxt  = 1'b1;
          retry_nxt = 3'd0;
          state_nxt = S_WAIT;
        end else begin
          retry_nxt = retry_cnt + 3'd1;
          state_nxt = S_REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_reward_place_ctrl.sv
// Bench for reward_place_ctrl: directed spawn/eat/retry/abort steps, then random candidate
// streams scored against a list-level placement model with an occupancy map.
module tb_reward_place_ctrl;
  localparam int BASE_TIME = 20;
  localparam int STAY_TIME = 40;
  localparam int MAX_RETRY = 7;
  localparam int X_MIN = 4;
  localparam int X_MAX = 19;
  localparam int Y_MIN = 2;
  localparam int Y_MAX = 9;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;
  logic tick   = 1'b0;

  int checks   = 0;
  int failures = 0;

  int score_tbl [4] = '{0, 1, 2, 5};
  bit occ_map [64][64];

  reward_place_ctrl_if bus ();

  reward_place_ctrl #(
    .BASE_TIME(BASE_TIME), .STAY_TIME(STAY_TIME), .MAX_RETRY(MAX_RETRY),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .tick(tick),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives the strobes for one clock and returns #1 after the edge, ready for sampling.
  task automatic applyStimulus(input logic tk, input logic cv, input logic ack, input logic hv);
    tick           = tk;
    bus.cand_valid = cv;
    bus.occ_ack    = ack;
    bus.head_valid = hv;
    cyc();
  endtask

  task automatic give_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_cand_req();
    int n = 0;
    while (bus.cand_req !== 1'b1 && n < 8) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("cand_req_wait", 32'(bus.cand_req), 1);
  endtask

  task automatic place_directed(input int nticks, input int x, input int y, input int t);
    give_ticks(nticks);
    checkOutput("req_after_base", 32'(bus.cand_req), 1);
    bus.cand_xpos = 6'(x);
    bus.cand_ypos = 6'(y);
    bus.cand_type = 2'(t);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("cand_req_drop", 32'(bus.cand_req), 0);
    checkOutput("occ_req_rise", 32'(bus.occ_req), 1);
    checkOutput("occ_x", 32'(bus.occ_x), 32'(x));
    checkOutput("occ_y", 32'(bus.occ_y), 32'(y));
    bus.occ_hit = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("placed_valid", 32'(bus.reward_valid), 1);
    checkOutput("placed_x", 32'(bus.reward_xpos), 32'(x));
    checkOutput("placed_y", 32'(bus.reward_ypos), 32'(y));
    checkOutput("placed_type", 32'(bus.reward_type), 32'(t));
    checkOutput("occ_req_done", 32'(bus.occ_req), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cx, cy, ct, rejects;
    bit legal, placed;

    bus.cand_valid = 1'b0;
    bus.cand_xpos  = 6'd0;
    bus.cand_ypos  = 6'd0;
    bus.cand_type  = 2'd0;
    bus.occ_ack    = 1'b0;
    bus.occ_hit    = 1'b0;
    bus.head_valid = 1'b0;
    bus.head_x     = 6'd0;
    bus.head_y     = 6'd0;

    // Reset state with enable already high
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) cyc();
    checkOutput("rst_reward_valid", 32'(bus.reward_valid), 0);
    checkOutput("rst_cand_req", 32'(bus.cand_req), 0);
    checkOutput("rst_occ_req", 32'(bus.occ_req), 0);
    checkOutput("rst_eaten", 32'(bus.eaten), 0);
    checkOutput("rst_score", 32'(bus.score_add), 0);
    checkOutput("rst_place_fail", 32'(bus.place_fail), 0);
    checkOutput("rst_reward_x", 32'(bus.reward_xpos), 0);
    checkOutput("rst_reward_type", 32'(bus.reward_type), 0);
    rst_n = 1'b1;
    cyc();

    // Stray handshakes in WAIT are ignored
    bus.cand_xpos = 6'd10;
    bus.cand_ypos = 6'd5;
    bus.cand_type = 2'd1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("wait_ignore_cand", 32'(bus.cand_req), 0);
    checkOutput("wait_ignore_occ", 32'(bus.occ_req), 0);
    checkOutput("wait_ignore_valid", 32'(bus.reward_valid), 0);

    // Clean spawn: request appears exactly on the BASE_TIME-th tick
    give_ticks(BASE_TIME - 1);
    checkOutput("no_req_before_base", 32'(bus.cand_req), 0);
    place_directed(1, 10, 5, 2);

`ifdef REWARD_TIMEOUT_EN
    give_ticks(STAY_TIME - 1);
    checkOutput("hold_before_expiry", 32'(bus.reward_valid), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    bus.head_x = 6'd10;
    bus.head_y = 6'd5;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("eat_on_expiry_eaten", 32'(bus.eaten), 1);
    checkOutput("eat_on_expiry_score", 32'(bus.score_add), 2);
    checkOutput("eat_on_expiry_valid", 32'(bus.reward_valid), 0);
`else
    give_ticks(100);
    checkOutput("hold_100_ticks", 32'(bus.reward_valid), 1);
    checkOutput("hold_100_x", 32'(bus.reward_xpos), 10);
    bus.head_x = 6'd10;
    bus.head_y = 6'd6;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("miss_eaten", 32'(bus.eaten), 0);
    checkOutput("miss_valid", 32'(bus.reward_valid), 1);
    bus.head_y = 6'd5;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("eat_eaten", 32'(bus.eaten), 1);
    checkOutput("eat_score", 32'(bus.score_add), 2);
    checkOutput("eat_valid", 32'(bus.reward_valid), 0);
    checkOutput("eat_x_cleared", 32'(bus.reward_xpos), 0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("eaten_one_cycle", 32'(bus.eaten), 0);
    checkOutput("score_one_cycle", 32'(bus.score_add), 0);

    // Type 3 reward scores 5
    place_directed(BASE_TIME, 10, 5, 3);
    bus.head_x = 6'd10;
    bus.head_y = 6'd5;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("eat3_eaten", 32'(bus.eaten), 1);
    checkOutput("eat3_score", 32'(bus.score_add), 5);
    checkOutput("eat3_type_cleared", 32'(bus.reward_type), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef REWARD_TIMEOUT_EN
    place_directed(BASE_TIME, 7, 3, 1);
    give_ticks(STAY_TIME);
    checkOutput("expired_valid", 32'(bus.reward_valid), 0);
    checkOutput("expired_no_eaten", 32'(bus.eaten), 0);
`endif

    // Retry limit: alternate out-of-range and occupied candidates
    give_ticks(BASE_TIME);
    for (int i = 0; i < MAX_RETRY; i++) begin
      wait_cand_req();
      if (i % 2 == 0) begin
        bus.cand_xpos = 6'd30;
        bus.cand_ypos = 6'd5;
        bus.cand_type = 2'd1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("retry_no_query", 32'(bus.occ_req), 0);
      end else begin
        bus.cand_xpos = 6'd12;
        bus.cand_ypos = 6'd4;
        bus.cand_type = 2'd1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("retry_query", 32'(bus.occ_req), 1);
        bus.occ_hit = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      end
      checkOutput("retry_place_fail", 32'(bus.place_fail), 32'(i == MAX_RETRY - 1));
      checkOutput("retry_no_reward", 32'(bus.reward_valid), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("place_fail_single", 32'(bus.place_fail), 0);
    checkOutput("fail_back_to_wait", 32'(bus.cand_req), 0);

    // Abort during the occupancy query; late answers are ignored
    give_ticks(BASE_TIME);
    wait_cand_req();
    bus.cand_xpos = 6'd15;
    bus.cand_ypos = 6'd8;
    bus.cand_type = 2'd2;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_query_up", 32'(bus.occ_req), 1);
    enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_occ_req", 32'(bus.occ_req), 0);
    checkOutput("abort_cand_req", 32'(bus.cand_req), 0);
    checkOutput("abort_occ_x", 32'(bus.occ_x), 0);
    checkOutput("abort_valid", 32'(bus.reward_valid), 0);
    bus.occ_hit = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("late_ack_disabled", 32'(bus.reward_valid), 0);
    enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("late_ack_enabled", 32'(bus.reward_valid), 0);

    // Disabling mid-WAIT restarts the spawn pacing from zero
    give_ticks(10);
    enable = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    give_ticks(BASE_TIME - 1);
    checkOutput("pacing_restarted", 32'(bus.cand_req), 0);
    give_ticks(1);
    checkOutput("pacing_req", 32'(bus.cand_req), 1);

    // Random rounds: first legal, unoccupied candidate wins; MAX_RETRY rejects abandon the spawn
    for (int r = 0; r < 24; r++) begin
      foreach (occ_map[i, j]) occ_map[i][j] = ($urandom_range(0, 2) == 0);
      placed  = 1'b0;
      rejects = 0;
      cx = 0;
      cy = 0;
      ct = 0;
      while (!placed && rejects < MAX_RETRY) begin
        wait_cand_req();
        cx = int'($urandom_range(0, 23));
        cy = int'($urandom_range(0, 11));
        ct = int'($urandom_range(0, 3));
        legal = (ct != 0) && (cx >= X_MIN) && (cx <= X_MAX) && (cy >= Y_MIN) && (cy <= Y_MAX);
        bus.cand_xpos = 6'(cx);
        bus.cand_ypos = 6'(cy);
        bus.cand_type = 2'(ct);
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        checkOutput("rnd_query", 32'(bus.occ_req), 32'(legal));
        if (legal) begin
          checkOutput("rnd_occ_x", 32'(bus.occ_x), 32'(cx));
          checkOutput("rnd_occ_y", 32'(bus.occ_y), 32'(cy));
          repeat ($urandom_range(0, 3)) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
          bus.occ_hit = occ_map[cx][cy];
          applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
          if (!occ_map[cx][cy]) placed = 1'b1;
          else                  rejects++;
        end else begin
          rejects++;
        end
        checkOutput("rnd_place_fail", 32'(bus.place_fail), 32'(!placed && rejects == MAX_RETRY));
        checkOutput("rnd_reward_valid", 32'(bus.reward_valid), 32'(placed));
      end
      if (placed) begin
        checkOutput("rnd_reward_x", 32'(bus.reward_xpos), 32'(cx));
        checkOutput("rnd_reward_y", 32'(bus.reward_ypos), 32'(cy));
        checkOutput("rnd_reward_type", 32'(bus.reward_type), 32'(ct));
        bus.head_x = 6'(cx ^ 1);
        bus.head_y = 6'(cy);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rnd_miss", 32'(bus.eaten), 0);
        bus.head_x = 6'(cx);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rnd_eaten", 32'(bus.eaten), 1);
        checkOutput("rnd_score", 32'(bus.score_add), 32'(score_tbl[ct]));
        checkOutput("rnd_cleared", 32'(bus.reward_valid), 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rnd_pulses_low", 32'({bus.eaten, bus.place_fail}), 0);
      give_ticks(BASE_TIME - 1);
      checkOutput("rnd_no_early_req", 32'(bus.cand_req), 0);
      give_ticks(1);
      checkOutput("rnd_req", 32'(bus.cand_req), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
